// File: rtl/imsic_msi_write_slave.sv
// AXI4-Lite write responder that turns MSI stores into IMSIC set-pending requests.
// Optional IMSIC_MSI_SLVERR_EN: unmapped addresses answer SLVERR instead of OKAY.
module imsic_msi_write_slave #(
    parameter int unsigned NR_SRC                = 30,
    parameter int unsigned NR_IMSICS             = 4,
    parameter int unsigned NR_VS_FILES_PER_IMSIC = 1,
    parameter int unsigned AXI_ADDR_WIDTH        = 64,
    parameter int unsigned AXI_DATA_WIDTH        = 64,
    parameter logic [63:0] M_BASE_ADDR           = 64'h2400_0000,
    parameter logic [63:0] S_BASE_ADDR           = 64'h2800_0000,
    localparam int unsigned ImsicW = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1,
    localparam int unsigned FileW  = $clog2(NR_VS_FILES_PER_IMSIC + 2),
    localparam int unsigned EiidW  = $clog2(NR_SRC)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_awvalid,
    output logic                        o_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
    input  logic                        i_wvalid,
    output logic                        o_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   i_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] i_wstrb,
    output logic                        o_bvalid,
    input  logic                        i_bready,
    output logic [1:0]                  o_bresp,
    output logic                        o_set_valid,
    input  logic                        i_set_ready,
    output logic [ImsicW-1:0]           o_set_imsic,
    output logic [FileW-1:0]            o_set_file,
    output logic [EiidW-1:0]            o_set_eiid
);

    localparam int unsigned FilesPerHart = NR_VS_FILES_PER_IMSIC + 1;
    localparam logic [63:0] MSize = 64'(NR_IMSICS) << 12;
    localparam logic [63:0] SSize = 64'(NR_IMSICS * FilesPerHart) << 12;

    typedef enum logic [2:0] {StIdle, StWaitW, StWaitAw, StIssue, StResp} state_e;

    state_e                      state_q, state_d;
    logic                        rst_hold_q;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q;

    logic        aw_fire, w_fire;
    logic [63:0] addr64, m_off, s_off;
    logic [31:0] m_page, s_page;
    logic        m_hit, s_hit, mapped, lane_sel, set_req;
    logic [31:0] lane_data;
    logic [3:0]  lane_strb;
    logic [ImsicW-1:0] dec_imsic;
    logic [FileW-1:0]  dec_file;
    logic [1:0]        resp_code;

    assign aw_fire = i_awvalid && o_awready;
    assign w_fire  = i_wvalid && o_wready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            rst_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rst_hold_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_fire) awaddr_q <= i_awaddr;
            if (w_fire) begin
                wdata_q <= i_wdata;
                wstrb_q <= i_wstrb;
            end
        end
    end

    // Decode is purely from the captured registers.
    always_comb begin
        addr64    = 64'(awaddr_q);
        m_off     = addr64 - M_BASE_ADDR;
        s_off     = addr64 - S_BASE_ADDR;
        m_page    = 32'(m_off >> 12);
        s_page    = 32'(s_off >> 12);
        m_hit     = (addr64 >= M_BASE_ADDR) && (addr64 < M_BASE_ADDR + MSize);
        s_hit     = (addr64 >= S_BASE_ADDR) && (addr64 < S_BASE_ADDR + SSize);
        mapped    = 1'b0;
        dec_imsic = '0;
        dec_file  = '0;
        if (m_hit) begin
            mapped    = 1'b1;
            dec_imsic = ImsicW'(m_page);
        end else if (s_hit) begin
            mapped    = 1'b1;
            dec_imsic = ImsicW'(s_page / FilesPerHart);
            dec_file  = FileW'(1 + (s_page % FilesPerHart));
        end
        lane_sel  = (AXI_DATA_WIDTH == 64) ? awaddr_q[2] : 1'b0;
        lane_data = lane_sel ? wdata_q[AXI_DATA_WIDTH-1 -: 32] : wdata_q[31:0];
        lane_strb = lane_sel ? wstrb_q[AXI_DATA_WIDTH/8-1 -: 4] : wstrb_q[3:0];
        set_req   = mapped && (addr64[11:0] == 12'h000) && (&lane_strb) &&
                    (lane_data >= 32'd1) && (lane_data < NR_SRC);
`ifdef IMSIC_MSI_SLVERR_EN
        resp_code = mapped ? 2'b00 : 2'b10;
`else
        resp_code = 2'b00;
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (aw_fire && w_fire) state_d = StIssue;
                else if (aw_fire)      state_d = StWaitW;
                else if (w_fire)       state_d = StWaitAw;
            end
            StWaitW:  if (w_fire) state_d = StIssue;
            StWaitAw: if (aw_fire) state_d = StIssue;
            StIssue:  if (!set_req || i_set_ready) state_d = StResp;
            StResp:   if (i_bready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Readies held low for the cycle in which reset was last sampled.
    always_comb begin
        o_awready   = !rst_hold_q && ((state_q == StIdle) || (state_q == StWaitAw));
        o_wready    = !rst_hold_q && ((state_q == StIdle) || (state_q == StWaitW));
        o_set_valid = (state_q == StIssue) && set_req;
        o_bvalid    = (state_q == StResp);
        o_bresp     = (state_q == StResp) ? resp_code : 2'b00;
        o_set_imsic = o_set_valid ? dec_imsic : '0;
        o_set_file  = o_set_valid ? dec_file : '0;
        o_set_eiid  = o_set_valid ? EiidW'(lane_data) : '0;
    end

endmodule

// File: tb/tb_imsic_msi_write_slave.sv
// Directed self-checking bench for imsic_msi_write_slave (default parameters).
module tb_imsic_msi_write_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        set_valid, set_ready;
    logic [63:0] awaddr, wdata;
    logic [7:0]  wstrb;
    logic [1:0]  bresp;
    logic [1:0]  set_imsic, set_file;
    logic [4:0]  set_eiid;

    int checks = 0;
    int fails  = 0;
    int set_hs = 0;
    int b_hs   = 0;
    int hs_before, b_before;

`ifdef IMSIC_MSI_SLVERR_EN
    localparam logic [1:0] UnmappedResp = 2'b10;
`else
    localparam logic [1:0] UnmappedResp = 2'b00;
`endif

    imsic_msi_write_slave dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_awvalid   (awvalid),
        .o_awready   (awready),
        .i_awaddr    (awaddr),
        .i_wvalid    (wvalid),
        .o_wready    (wready),
        .i_wdata     (wdata),
        .i_wstrb     (wstrb),
        .o_bvalid    (bvalid),
        .i_bready    (bready),
        .o_bresp     (bresp),
        .o_set_valid (set_valid),
        .i_set_ready (set_ready),
        .o_set_imsic (set_imsic),
        .o_set_file  (set_file),
        .o_set_eiid  (set_eiid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (set_valid && set_ready) set_hs <= set_hs + 1;
        if (bvalid && bready) b_hs <= b_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_both(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        awvalid = 1'b1; awaddr = a;
        wvalid  = 1'b1; wdata  = d; wstrb = s;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic drop(input string tag, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input logic [1:0] exp_resp);
        write_both(a, d, s);
        chk({tag, "_no_set"}, set_valid, 0);
        tick();
        chk({tag, "_bvalid"}, bvalid, 1);
        chk({tag, "_bresp"}, bresp, exp_resp);
        tick();
    endtask

    initial begin
        rst = 1'b1; awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0; wstrb = 0;
        bready = 0; set_ready = 0;
        tick(); tick();
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_set_valid", set_valid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_imsic", set_imsic, 0);
        chk("rst_file", set_file, 0);
        chk("rst_eiid", set_eiid, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_awready", awready, 1);
        chk("post_rst_wready", wready, 1);

        // AW and W together, M file of hart 2
        set_ready = 1; bready = 1;
        write_both(64'h2400_2000, 64'h5, 8'h0F);
        chk("t1_set_valid", set_valid, 1);
        chk("t1_imsic", set_imsic, 2);
        chk("t1_file", set_file, 0);
        chk("t1_eiid", set_eiid, 5);
        chk("t1_awready_busy", awready, 0);
        tick();
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 0);
        chk("t1_set_hs", set_hs, 1);
        tick();
        chk("t1_idle_bvalid", bvalid, 0);
        chk("t1_idle_awready", awready, 1);

        // W first, AW three cycles later, set_ready stalled
        set_ready = 0;
        wvalid = 1; wdata = 64'h1D; wstrb = 8'h0F;
        tick();
        wvalid = 0;
        chk("t2_wait_awready", awready, 1);
        chk("t2_wait_wready", wready, 0);
        tick(); tick();
        awvalid = 1; awaddr = 64'h2800_2000;
        tick();
        awvalid = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t2_stall_valid", set_valid, 1);
            chk("t2_stall_imsic", set_imsic, 1);
            chk("t2_stall_file", set_file, 1);
            chk("t2_stall_eiid", set_eiid, 29);
            tick();
        end
        set_ready = 1;
        tick();
        chk("t2_single_hs", set_hs, 2);
        chk("t2_bvalid", bvalid, 1);
        tick();
        chk("t2_b_hs", b_hs, 2);

        // Page 3 of the S region is hart 1, VS1
        write_both(64'h2800_3000, 64'h2, 8'h0F);
        chk("t2b_set_valid", set_valid, 1);
        chk("t2b_imsic", set_imsic, 1);
        chk("t2b_file", set_file, 2);
        chk("t2b_eiid", set_eiid, 2);
        tick(); tick();

        drop("off_nz", 64'h2800_1004, 64'h0000_0007_0000_0000, 8'hF0, 2'b00);
        drop("eiid0", 64'h2400_0000, 64'h0, 8'h0F, 2'b00);
        drop("eiid30", 64'h2400_0000, 64'h1E, 8'h0F, 2'b00);
        drop("part_strb", 64'h2400_1000, 64'h5, 8'h07, 2'b00);
        drop("past_m", 64'h2400_4000, 64'h5, 8'h0F, UnmappedResp);
        drop("unmapped", 64'h3000_0000, 64'h5, 8'h0F, UnmappedResp);
        chk("drop_set_hs", set_hs, 3);

        // B held off while a new AW/W waits
        bready = 0;
        write_both(64'h2400_0000, 64'h3, 8'h0F);
        chk("t4_set_valid", set_valid, 1);
        chk("t4_eiid", set_eiid, 3);
        tick();
        awvalid = 1; awaddr = 64'h2400_1000;
        wvalid = 1; wdata = 64'h7; wstrb = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_bvalid", bvalid, 1);
            chk("t4_stall_awready", awready, 0);
            chk("t4_stall_wready", wready, 0);
            tick();
        end
        bready = 1;
        tick();
        chk("t4_idle_awready", awready, 1);
        chk("t4_idle_bvalid", bvalid, 0);
        tick();
        awvalid = 0; wvalid = 0;
        chk("t4_second_valid", set_valid, 1);
        chk("t4_second_imsic", set_imsic, 1);
        chk("t4_second_eiid", set_eiid, 7);
        tick();
        chk("t4_second_bvalid", bvalid, 1);
        tick();

        // Reset while ISSUE is pending
        set_ready = 0;
        write_both(64'h2400_2000, 64'hA, 8'h0F);
        chk("t5_set_valid", set_valid, 1);
        hs_before = set_hs;
        b_before  = b_hs;
        rst = 1;
        tick();
        chk("t5_rst_awready", awready, 0);
        chk("t5_rst_wready", wready, 0);
        chk("t5_rst_bvalid", bvalid, 0);
        chk("t5_rst_set_valid", set_valid, 0);
        chk("t5_rst_bresp", bresp, 0);
        chk("t5_rst_eiid", set_eiid, 0);
        rst = 0;
        tick();
        chk("t5_post_awready", awready, 1);
        chk("t5_post_bvalid", bvalid, 0);
        chk("t5_no_set_hs", set_hs, hs_before);
        chk("t5_no_b_hs", b_hs, b_before);
        set_ready = 1;
        write_both(64'h2400_3000, 64'h1, 8'h0F);
        chk("t5_new_valid", set_valid, 1);
        chk("t5_new_imsic", set_imsic, 3);
        chk("t5_new_eiid", set_eiid, 1);
        tick();
        chk("t5_new_bvalid", bvalid, 1);
        tick();
        chk("t5_new_b_hs", b_hs, b_before + 1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
